// File: rtl/spoke_bridge_pkg.sv
// Shared constants for the UART-to-memory command bridge: frame opcodes,
// response bytes, FSM state encoding and small helpers.
// No ports (package).
package spoke_bridge_pkg;

    // Frame opcodes (first byte of a frame)
    localparam logic [7:0] OP_WRITE = 8'h57;   // 'W'
    localparam logic [7:0] OP_READ  = 8'h52;   // 'R'
    localparam logic [7:0] OP_PING  = 8'h50;   // 'P'

    // Response bytes
    localparam logic [7:0] RSP_OK   = 8'h4B;   // 'K'
    localparam logic [7:0] RSP_ERR  = 8'h3F;   // '?'

    // FSM state encoding
    localparam int unsigned STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_ADDR_HI = 3'd1;
    localparam logic [STATE_W-1:0] ST_ADDR_LO = 3'd2;
    localparam logic [STATE_W-1:0] ST_DATA    = 3'd3;
    localparam logic [STATE_W-1:0] ST_BUS     = 3'd4;
    localparam logic [STATE_W-1:0] ST_RESP    = 3'd5;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = ST_IDLE,
        ADDR_HI = ST_ADDR_HI,
        ADDR_LO = ST_ADDR_LO,
        DATA    = ST_DATA,
        BUS     = ST_BUS,
        RESP    = ST_RESP
    } state_e;

    // Counter width able to hold cycles (at least 1 bit, also for cycles == 0)
    function automatic int unsigned timer_width(input int unsigned cycles);
        if (cycles < 2) begin
            return 1;
        end
        return $clog2(cycles + 1);
    endfunction

    // Big-endian join of the two address bytes
    function automatic logic [15:0] join_addr(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/bridge_timeout.sv
// Inter-byte timeout: loadable down-counter. Reloads on load_i, counts down
// while en_i, and flags expired_c_o in the cycle whose edge would take the
// count to zero (so exactly TIMEOUT_CYCLES idle cycles abort the frame).
// A load on that same edge takes priority. TIMEOUT_CYCLES == 0 disables it.
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous active-high reset, clears the count
//   load_i       reload count with TIMEOUT_CYCLES
//   en_i         count down this cycle
//   expired_c_o  combinational: timeout fires on the coming edge
module bridge_timeout
    import spoke_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 12_000_000,
    parameter int unsigned CNT_W          = timer_width(TIMEOUT_CYCLES)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic expired_c_o
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [CNT_W-1:0] count_q;

    // Count state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= RELOAD;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - ONE;
        end
    end

    assign expired_c_o = (TIMEOUT_CYCLES != 0) && en_i && !load_i && (count_q == ONE);

endmodule

// File: rtl/uart_mem_bridge.sv
// UART command endpoint: parses 'W' addr_hi addr_lo data / 'R' addr_hi addr_lo /
// 'P' frames from the received byte stream, runs one cycle on an 8-bit memory
// bus per read/write, and returns one response byte per frame.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   rx_byte_i/rx_valid_i/rx_ready_o   received byte handshake
//   tx_byte_o/tx_valid_o/tx_ready_i   response byte handshake
//   mem_addr_o/mem_wdata_o/mem_we_o/mem_valid_o   bus request (held to mem_ready_i)
//   mem_rdata_i/mem_ready_i          bus completion and read data
module uart_mem_bridge
    import spoke_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 12_000_000,
    parameter int unsigned ADDR_W         = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        rx_byte_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic [7:0]        tx_byte_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_valid_o,
    input  logic [7:0]        mem_rdata_i,
    input  logic              mem_ready_i
);

    state_e            state_q;
    logic              rx_ready_q;
    logic [7:0]        tx_byte_q;
    logic              tx_valid_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              mem_we_q;
    logic              mem_valid_q;
    logic [7:0]        addr_hi_q;
    logic              is_write_q;

    logic rx_fire;
    logic tmo_en;
    logic tmo_expired;

    assign rx_fire = rx_valid_i && rx_ready_q;
    // Timer only runs while a frame is partially received
    assign tmo_en  = (state_q == ADDR_HI) || (state_q == ADDR_LO) || (state_q == DATA);

    bridge_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (rx_fire),
        .en_i        (tmo_en),
        .expired_c_o (tmo_expired)
    );

    // Frame FSM with registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rx_ready_q  <= 1'b0;
            tx_byte_q   <= '0;
            tx_valid_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_valid_q <= 1'b0;
            addr_hi_q   <= '0;
            is_write_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rx_ready_q <= 1'b1;
                    if (rx_fire) begin
                        case (rx_byte_i)
                            OP_WRITE: begin
                                is_write_q <= 1'b1;
                                state_q    <= ADDR_HI;
                            end
                            OP_READ: begin
                                is_write_q <= 1'b0;
                                state_q    <= ADDR_HI;
                            end
                            OP_PING: begin
                                rx_ready_q <= 1'b0;
                                tx_byte_q  <= RSP_OK;
                                tx_valid_q <= 1'b1;
                                state_q    <= RESP;
                            end
                            default: begin
                                // Unknown opcode: answer at once, consume nothing more
                                rx_ready_q <= 1'b0;
                                tx_byte_q  <= RSP_ERR;
                                tx_valid_q <= 1'b1;
                                state_q    <= RESP;
                            end
                        endcase
                    end
                end

                ADDR_HI: begin
                    if (rx_fire) begin
                        addr_hi_q <= rx_byte_i;
                        state_q   <= ADDR_LO;
                    end else if (tmo_expired) begin
                        state_q <= IDLE;
                    end
                end

                ADDR_LO: begin
                    if (rx_fire) begin
                        mem_addr_q <= ADDR_W'(join_addr(addr_hi_q, rx_byte_i));
                        if (is_write_q) begin
                            state_q <= DATA;
                        end else begin
                            mem_we_q    <= 1'b0;
                            mem_valid_q <= 1'b1;
                            rx_ready_q  <= 1'b0;
                            state_q     <= BUS;
                        end
                    end else if (tmo_expired) begin
                        state_q <= IDLE;
                    end
                end

                DATA: begin
                    if (rx_fire) begin
                        mem_wdata_q <= rx_byte_i;
                        mem_we_q    <= 1'b1;
                        mem_valid_q <= 1'b1;
                        rx_ready_q  <= 1'b0;
                        state_q     <= BUS;
                    end else if (tmo_expired) begin
                        state_q <= IDLE;
                    end
                end

                BUS: begin
                    if (mem_ready_i) begin
                        mem_valid_q <= 1'b0;
                        tx_byte_q   <= mem_we_q ? RSP_OK : mem_rdata_i;
                        tx_valid_q  <= 1'b1;
                        state_q     <= RESP;
                    end
                end

                RESP: begin
                    if (tx_ready_i) begin
                        tx_valid_q <= 1'b0;
                        rx_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    rx_ready_q  <= 1'b0;
                    tx_valid_q  <= 1'b0;
                    mem_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ready_o  = rx_ready_q;
    assign tx_byte_o   = tx_byte_q;
    assign tx_valid_o  = tx_valid_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_we_o    = mem_we_q;
    assign mem_valid_o = mem_valid_q;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Scoreboard bench for uart_mem_bridge: stimulus pushes expected bus requests
// and response bytes into queues; negedge monitors pop and compare.
module tb_uart_mem_bridge;

    localparam int unsigned TMO    = 20;
    localparam int unsigned ADDR_W = 16;

    logic              clk;
    logic              rst_i;
    logic [7:0]        rx_byte_i;
    logic              rx_valid_i;
    logic              rx_ready_o;
    logic [7:0]        tx_byte_o;
    logic              tx_valid_o;
    logic              tx_ready_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_wdata_o;
    logic              mem_we_o;
    logic              mem_valid_o;
    logic [7:0]        mem_rdata_i;
    logic              mem_ready_i;

    uart_mem_bridge #(
        .TIMEOUT_CYCLES (TMO),
        .ADDR_W         (ADDR_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .rx_byte_i   (rx_byte_i),
        .rx_valid_i  (rx_valid_i),
        .rx_ready_o  (rx_ready_o),
        .tx_byte_o   (tx_byte_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_we_o    (mem_we_o),
        .mem_valid_o (mem_valid_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ready_i (mem_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } bus_op_t;

    bus_op_t    bus_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] ref_mem [0:65535];   // reference model of memory contents
    logic [7:0] slv_mem [0:65535];   // bus slave storage, written by DUT writes

    int n_cmp = 0;
    int n_bad = 0;
    int bus_wait = -1;   // <0: random wait states
    bit tx_hold = 1'b0;
    int bus_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string why);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s (t=%0t)", name, why, $time);
    endtask

    // Monitors: sample away from the rising edge
    always @(negedge clk) begin
        if (!rst_i) begin
            if (mem_valid_o) begin
                bus_cycles++;
                if (bus_q.size() == 0) begin
                    fail_now("bus_unexpected", $sformatf("got addr %0h we %0b, none expected", mem_addr_o, mem_we_o));
                end else begin
                    check("bus_req",
                          32'({mem_we_o, 16'(mem_addr_o), mem_we_o ? mem_wdata_o : 8'h00}),
                          32'({bus_q[0].we, bus_q[0].addr, bus_q[0].we ? bus_q[0].data : 8'h00}));
                    check("rx_ready_in_bus", 32'(rx_ready_o), 32'(0));
                    check("tx_valid_in_bus", 32'(tx_valid_o), 32'(0));
                    if (mem_ready_i) begin
                        if (mem_we_o) slv_mem[16'(mem_addr_o)] = mem_wdata_o;
                        void'(bus_q.pop_front());
                    end
                end
            end
            if (tx_valid_o) begin
                if (tx_q.size() == 0) begin
                    fail_now("tx_unexpected", $sformatf("got byte %0h, none expected", tx_byte_o));
                end else begin
                    check("tx_byte", 32'(tx_byte_o), 32'(tx_q[0]));
                    check("rx_ready_in_resp", 32'(rx_ready_o), 32'(0));
                    if (tx_ready_i) void'(tx_q.pop_front());
                end
            end
        end
    end

    // Memory bus slave with programmable or random wait states
    initial begin : bus_slave
        bit busy;
        int cnt;
        busy = 1'b0;
        cnt = 0;
        mem_ready_i = 1'b0;
        mem_rdata_i = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (rst_i) begin
                mem_ready_i = 1'b0;
                busy = 1'b0;
            end else begin
                mem_ready_i = 1'b0;
                mem_rdata_i = 8'($urandom);
                if (mem_valid_o) begin
                    if (!busy) begin
                        busy = 1'b1;
                        cnt = (bus_wait < 0) ? int'($urandom_range(0, 3)) : bus_wait;
                    end
                    if (cnt == 0) begin
                        mem_ready_i = 1'b1;
                        mem_rdata_i = slv_mem[16'(mem_addr_o)];
                        busy = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // UART transmitter readiness
    initial begin : tx_drv
        tx_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_ready_i = tx_hold ? 1'b0 : (($urandom % 4) != 0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one byte until accepted; returns just after the accepting edge
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_byte_i = b;
        rx_valid_i = 1'b1;
        forever begin
            @(negedge clk);
            if (rx_ready_o) break;
            n++;
            if (n > 400) begin
                fail_now("rx_accept_timeout", $sformatf("byte %0h never accepted", b));
                break;
            end
        end
        @(posedge clk);
        #1;
        rx_valid_i = 1'b0;
        rx_byte_i = 8'($urandom);
    endtask

    task automatic gap(input int maxg);
        idle(int'($urandom_range(0, maxg)));
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int maxg);
        bus_q.push_back('{we: 1'b1, addr: a, data: d});
        tx_q.push_back(8'h4B);
        ref_mem[a] = d;
        send_byte(8'h57); gap(maxg);
        send_byte(a[15:8]); gap(maxg);
        send_byte(a[7:0]); gap(maxg);
        send_byte(d);
    endtask

    task automatic do_read(input logic [15:0] a, input int maxg);
        bus_q.push_back('{we: 1'b0, addr: a, data: 8'h00});
        tx_q.push_back(ref_mem[a]);
        send_byte(8'h52); gap(maxg);
        send_byte(a[15:8]); gap(maxg);
        send_byte(a[7:0]);
    endtask

    task automatic do_ping();
        tx_q.push_back(8'h4B);
        send_byte(8'h50);
    endtask

    task automatic do_bad(input logic [7:0] op);
        tx_q.push_back(8'h3F);
        send_byte(op);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((bus_q.size() != 0 || tx_q.size() != 0 || tx_valid_o || mem_valid_o) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 1000) fail_now("drain_timeout", $sformatf("bus_q=%0d tx_q=%0d pending", bus_q.size(), tx_q.size()));
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [7:0] v;
        logic [7:0] op;
        logic [15:0] a;
        int b0;
        int r;

        rst_i = 1'b1;
        rx_valid_i = 1'b0;
        rx_byte_i = 8'h00;
        for (int i = 0; i < 65536; i++) begin
            v = 8'($urandom);
            ref_mem[i] = v;
            slv_mem[i] = v;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rx_ready", 32'(rx_ready_o), 32'(0));
        check("rst_tx_valid", 32'(tx_valid_o), 32'(0));
        check("rst_tx_byte", 32'(tx_byte_o), 32'(0));
        check("rst_mem_valid", 32'(mem_valid_o), 32'(0));
        check("rst_mem_we", 32'(mem_we_o), 32'(0));
        check("rst_mem_addr", 32'(mem_addr_o), 32'(0));
        check("rst_mem_wdata", 32'(mem_wdata_o), 32'(0));
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        check("rx_ready_after_reset", 32'(rx_ready_o), 32'(1));

        // Single-cycle write
        bus_wait = 0;
        b0 = bus_cycles;
        do_write(16'h1234, 8'hA5, 0);
        wait_drain();
        check("write_bus_cycles", 32'(bus_cycles - b0), 32'(1));

        // Read with three wait states
        ref_mem[16'h0010] = 8'h5C;
        slv_mem[16'h0010] = 8'h5C;
        bus_wait = 3;
        b0 = bus_cycles;
        do_read(16'h0010, 0);
        wait_drain();
        check("read_bus_cycles", 32'(bus_cycles - b0), 32'(4));
        bus_wait = -1;

        // Unknown opcode then ping: no bus activity
        b0 = bus_cycles;
        do_bad(8'h00);
        do_ping();
        wait_drain();
        check("ping_bus_cycles", 32'(bus_cycles - b0), 32'(0));

        // Timeout after a partial write, then a fresh read
        send_byte(8'h57);
        send_byte(8'h12);
        idle(25);
        do_read(16'h0001, 0);
        wait_drain();

        // Byte arriving on the expiry edge is still taken
        send_byte(8'h57); idle(TMO - 1);
        send_byte(8'h00); idle(TMO - 1);
        send_byte(8'h02); idle(TMO - 1);
        bus_q.push_back('{we: 1'b1, addr: 16'h0002, data: 8'h77});
        tx_q.push_back(8'h4B);
        ref_mem[16'h0002] = 8'h77;
        send_byte(8'h77);
        wait_drain();
        // One cycle later is too late
        send_byte(8'h52); idle(TMO);
        do_ping();
        wait_drain();
        do_read(16'h0002, 2);
        wait_drain();

        // Transmit backpressure for 50 cycles
        tx_hold = 1'b1;
        do_ping();
        idle(3);
        check("bp_tx_valid_start", 32'(tx_valid_o), 32'(1));
        idle(50);
        check("bp_tx_valid_held", 32'(tx_valid_o), 32'(1));
        check("bp_rx_ready_low", 32'(rx_ready_o), 32'(0));
        tx_hold = 1'b0;
        wait_drain();

        // Asynchronous reset in the middle of a bus wait
        bus_wait = 10;
        do_read(16'h0042, 0);
        idle(2);
        check("pre_rst_mem_valid", 32'(mem_valid_o), 32'(1));
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst_mem_valid", 32'(mem_valid_o), 32'(0));
        check("async_rst_tx_valid", 32'(tx_valid_o), 32'(0));
        check("async_rst_rx_ready", 32'(rx_ready_o), 32'(0));
        bus_q.delete();
        tx_q.delete();
        idle(3);
        rst_i = 1'b0;
        bus_wait = -1;
        idle(2);
        do_write(16'hBEEF, 8'h3C, 2);
        do_read(16'hBEEF, 2);
        wait_drain();

        // Randomized frames
        for (int i = 0; i < 80; i++) begin
            r = int'($urandom % 10);
            a = (($urandom % 4) == 0) ? 16'($urandom) : 16'(16'h0100 + ($urandom % 16));
            case (r)
                0, 1, 2: do_write(a, 8'($urandom), 5);
                3, 4, 5: do_read(a, 5);
                6:       do_ping();
                7: begin
                    do op = 8'($urandom);
                    while (op == 8'h57 || op == 8'h52 || op == 8'h50);
                    do_bad(op);
                end
                default: begin
                    send_byte((($urandom % 2) == 0) ? 8'h57 : 8'h52);
                    if (($urandom % 2) == 0) send_byte(8'($urandom));
                    idle(TMO + 2);
                end
            endcase
            gap(3);
        end
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_mem_bridge.md
Name: uart_mem_bridge

Overview:
Host-side command endpoint on the far end of the UART byte stream. It consumes received bytes (rx_valid/rx_ready), parses framed read/write commands, and executes them on a simple 8-bit memory bus. It returns one response byte per command through the UART transmit handshake (tx_valid/tx_ready). It sits between the uart block and on-chip registers/RAM, giving a serial debug/peek-poke path.

Parameters:
TIMEOUT_CYCLES, 12_000_000, idle clocks allowed between bytes of one frame before abort (1 s at 12 MHz); 0 disables timeout
ADDR_W, 16, memory address width; fixed two address bytes, upper bits beyond ADDR_W ignored

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx_byte  in  8  received byte from uart
rx_valid  in  1  rx_byte holds a new byte
rx_ready  out  1  bridge accepts rx_byte this cycle
tx_byte  out  8  response byte to uart
tx_valid  out  1  tx_byte valid, held until accepted
tx_ready  in  1  uart transmitter idle/accepting
mem_addr  out  ADDR_W  bus address
mem_wdata  out  8  write data
mem_we  out  1  1=write, 0=read; qualified by mem_valid
mem_valid  out  1  bus request, held until mem_ready
mem_rdata  in  8  read data, sampled when mem_valid && mem_ready
mem_ready  in  1  bus completes request this cycle

Behaviour:
- Reset is asynchronous, active-high. During/after reset: state=IDLE; rx_ready=0 while reset is high, then 1 from the first cycle after release; tx_valid=0, tx_byte=0, mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0; timer cleared.
- Byte transfer: a byte is taken on the edge where rx_valid && rx_ready. Transmit transfer: on the edge where tx_valid && tx_ready; tx_valid drops the next cycle. tx_byte/tx_valid are registered and stable while waiting.
- Frame format (address big-endian):
  - 'W' (0x57), addr_hi, addr_lo, data -> write; response 'K' (0x4B).
  - 'R' (0x52), addr_hi, addr_lo -> read; response = read byte.
  - 'P' (0x50) -> ping; response 'K', no bus cycle.
  - Any other first byte -> response '?' (0x3F); no further bytes consumed for that frame.
- States:
  - IDLE: rx_ready=1; decode opcode.
  - ADDR_HI, ADDR_LO: rx_ready=1; capture address bytes.
  - DATA: rx_ready=1; writes only.
  - BUS: rx_ready=0; mem_valid=1 with mem_addr/mem_we/mem_wdata stable until mem_ready. mem_ready in the first BUS cycle completes in one cycle. Read data is captured on the completing edge.
  - RESP: rx_ready=0; tx_valid=1 until accepted, then IDLE.
- Latency: mem_valid rises the cycle after the last frame byte is accepted. tx_valid rises the cycle after the mem_ready edge. For ping/unknown, tx_valid rises the cycle after the opcode is accepted.
- rx_ready is 0 in BUS and RESP. The bridge never drops bytes itself; overrun while busy is the uart's responsibility.
- Timeout: the timer reloads with TIMEOUT_CYCLES on every accepted byte and counts down in ADDR_HI/ADDR_LO/DATA only. When it reaches 0, the bridge returns to IDLE with no response and no bus cycle. Not active in IDLE/BUS/RESP. A byte accepted on the same edge the timer hits 0 wins: the byte is taken and the timer reloads.
- tx_ready held low indefinitely: remain in RESP; the bus is not touched.
- Reset mid-frame or mid-bus: all outputs clear immediately; the partial frame is discarded.

Decomposition:
- Package spoke_bridge_pkg holds:
  - opcode constants OP_WRITE=0x57, OP_READ=0x52, OP_PING=0x50;
  - response constants RSP_OK=0x4B, RSP_ERR=0x3F;
  - state encoding localparams (3 bits: IDLE, ADDR_HI, ADDR_LO, DATA, BUS, RESP).
- One sub-module, bridge_timeout: loadable down-counter with enable, load and expired outputs, parameterised by TIMEOUT_CYCLES and width.
- FSM and datapath stay in uart_mem_bridge.

Test Plan:
- Write: bytes 57,12,34,A5 with mem_ready tied 1 -> one cycle with mem_valid=1, mem_we=1, mem_addr=0x1234, mem_wdata=0xA5; then tx_byte=0x4B.
- Read with wait states: bytes 52,00,10, mem_ready delayed 3 cycles, mem_rdata=0x5C -> mem_valid held 4 cycles with addr stable; tx_byte=0x5C; rx_ready=0 throughout.
- Unknown/ping: bytes 00 then 50 -> responses 0x3F then 0x4B, in order; no mem_valid.
- Timeout (TIMEOUT_CYCLES=20): bytes 57,12 then silence -> back to IDLE after 20 cycles, no response. Next frame 52,00,01 reads addr 0x0001 correctly.
- TX backpressure: tx_ready=0 for 50 cycles during response -> tx_valid and tx_byte stable, rx_ready=0; accepted exactly once when tx_ready rises.
- Async reset asserted in BUS mid-wait -> mem_valid, tx_valid and rx_ready fall without a clock edge. After release, a full write frame works.
